vga_timing_controller: RTL and testbench

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

---
 rtl/vga_timing_controller_if.sv | 35 +++
 rtl/vga_timing_controller.sv | 149 ++++++++++++++
 tb/tb_vga_timing_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_controller_if
//  Description : Run-enable and video timing outputs of the VGA timing
//                controller, bundled as one interface.
//                The master side drives enable_in and receives the outputs.
//                The slave side is the timing controller itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_controller_if #(
   parameter int WIDTH_BITS  = 10,
   parameter int HEIGHT_BITS = 9
);
   logic                   enable_in;
   logic [WIDTH_BITS-1:0]  pixel_x_out;
   logic [HEIGHT_BITS-1:0] pixel_y_out;
   logic                   video_on_out;
   logic                   h_sync_out;
   logic                   v_sync_out;
   logic                   pixel_tick_out;
   logic                   frame_start_out;

   modport master (
      output enable_in,
      input  pixel_x_out, pixel_y_out, video_on_out, h_sync_out,
      input  v_sync_out, pixel_tick_out, frame_start_out
   );

   modport slave (
      input  enable_in,
      output pixel_x_out, pixel_y_out, video_on_out, h_sync_out,
      output v_sync_out, pixel_tick_out, frame_start_out
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_controller
//  Description : VGA raster timing generator.
//                A clock divider produces a pixel tick.
//                On each tick the registered outputs take the decode of the
//                current (h,v) position, and the counters step to the next
//                position.
//                Dropping enable_in returns everything to the idle state.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_controller #(
   parameter int H_DISPLAY   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int WIDTH_BITS  = 10,
   parameter int HEIGHT_BITS = 9,
   parameter int CLOCK_DIV   = 2
) (
   input  logic                    clock_in,
   input  logic                    reset_n_in,
   vga_timing_controller_if.slave  vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   // A divide-by-one still needs a 1-bit register to keep the logic uniform
   localparam int DIV_W   = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

   localparam logic [H_W-1:0]   H_LAST       = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]   H_VIS_END    = H_W'(H_DISPLAY);
   localparam logic [H_W-1:0]   H_SYNC_FIRST = H_W'(H_DISPLAY + H_FRONT);
   localparam logic [H_W-1:0]   H_SYNC_LAST  = H_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [V_W-1:0]   V_LAST       = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]   V_VIS_END    = V_W'(V_DISPLAY);
   localparam logic [V_W-1:0]   V_SYNC_FIRST = V_W'(V_DISPLAY + V_FRONT);
   localparam logic [V_W-1:0]   V_SYNC_LAST  = V_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLOCK_DIV - 1);

   logic [DIV_W-1:0]       div_q, div_d;
   logic [H_W-1:0]         h_count_q, h_count_d;
   logic [V_W-1:0]         v_count_q, v_count_d;

   logic [WIDTH_BITS-1:0]  pixel_x_q;
   logic [HEIGHT_BITS-1:0] pixel_y_q;
   logic                   video_on_q;
   logic                   h_sync_q;
   logic                   v_sync_q;
   logic                   pixel_tick_q;
   logic                   frame_start_q;

   logic                   w_tick;
   logic                   w_h_vis;
   logic                   w_v_vis;
   logic                   w_h_sync_n;
   logic                   w_v_sync_n;
   logic                   w_at_origin;

   assign w_tick = vga.enable_in && (div_q == DIV_LAST);

   // Decode of the position currently held in the counters
   assign w_h_vis     = (h_count_q < H_VIS_END);
   assign w_v_vis     = (v_count_q < V_VIS_END);
   assign w_h_sync_n  = !((h_count_q >= H_SYNC_FIRST) && (h_count_q <= H_SYNC_LAST));
   assign w_v_sync_n  = !((v_count_q >= V_SYNC_FIRST) && (v_count_q <= V_SYNC_LAST));
   assign w_at_origin = (h_count_q == '0) && (v_count_q == '0);

   // Next-state of the divider and the raster counters
   always_comb begin
      div_d     = div_q;
      h_count_d = h_count_q;
      v_count_d = v_count_q;
      if (!vga.enable_in) begin
         div_d     = '0;
         h_count_d = '0;
         v_count_d = '0;
      end else begin
         div_d = w_tick ? '0 : div_q + 1'b1;
         if (w_tick) begin
            h_count_d = (h_count_q == H_LAST) ? '0 : h_count_q + 1'b1;
            if (h_count_q == H_LAST) begin
               v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
            end
         end
      end
   end

   // Divider and raster counter registers
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         div_q     <= '0;
         h_count_q <= '0;
         v_count_q <= '0;
      end else begin
         div_q     <= div_d;
         h_count_q <= h_count_d;
         v_count_q <= v_count_d;
      end
   end

   // Output registers: load the decode on a tick, hold between ticks, idle when disabled
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         video_on_q    <= 1'b0;
         h_sync_q      <= 1'b1;
         v_sync_q      <= 1'b1;
         pixel_tick_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (!vga.enable_in) begin
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         video_on_q    <= 1'b0;
         h_sync_q      <= 1'b1;
         v_sync_q      <= 1'b1;
         pixel_tick_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (w_tick) begin
         pixel_x_q     <= w_h_vis ? WIDTH_BITS'(h_count_q) : '0;
         pixel_y_q     <= w_v_vis ? HEIGHT_BITS'(v_count_q) : '0;
         video_on_q    <= w_h_vis && w_v_vis;
         h_sync_q      <= w_h_sync_n;
         v_sync_q      <= w_v_sync_n;
         pixel_tick_q  <= 1'b1;
         frame_start_q <= w_at_origin;
      end else begin
         pixel_tick_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end
   end

   assign vga.pixel_x_out     = pixel_x_q;
   assign vga.pixel_y_out     = pixel_y_q;
   assign vga.video_on_out    = video_on_q;
   assign vga.h_sync_out      = h_sync_q;
   assign vga.v_sync_out      = v_sync_q;
   assign vga.pixel_tick_out  = pixel_tick_q;
   assign vga.frame_start_out = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_controller
//  Description : Self-checking bench for vga_timing_controller.
//                Instance A uses the default 640x480 timing with CLOCK_DIV=2.
//                Instance B uses a reduced 16x11 raster with CLOCK_DIV=1, so
//                that whole frames, the mid-frame disable and the mid-sync
//                reset fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_controller;

   logic clk = 1'b0;
   logic rst_a_n;
   logic rst_b_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   vga_timing_controller_if #(.WIDTH_BITS(10), .HEIGHT_BITS(9)) ifa ();
   vga_timing_controller_if #(.WIDTH_BITS(4),  .HEIGHT_BITS(3)) ifb ();

   vga_timing_controller u_dut_a (
      .clock_in   (clk),
      .reset_n_in (rst_a_n),
      .vga        (ifa)
   );

   // Reduced raster: H 8+2+3+3=16 (h-sync 10..12), V 6+1+2+2=11 (v-sync 7..8)
   vga_timing_controller #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .WIDTH_BITS(4), .HEIGHT_BITS(3), .CLOCK_DIV(1)
   ) u_dut_b (
      .clock_in   (clk),
      .reset_n_in (rst_b_n),
      .vga        (ifb)
   );

   typedef struct {
      int n;     // rising edges since enable, sampled 1 time unit later
      int x;
      int y;
      int vid;
      int hs;
      int vs;
      int tk;
      int fs;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, " x"},   int'(ifa.pixel_x_out), 0);
      chk({tag, " y"},   int'(ifa.pixel_y_out), 0);
      chk({tag, " vid"}, int'(ifa.video_on_out), 0);
      chk({tag, " hs"},  int'(ifa.h_sync_out), 1);
      chk({tag, " vs"},  int'(ifa.v_sync_out), 1);
      chk({tag, " tk"},  int'(ifa.pixel_tick_out), 0);
      chk({tag, " fs"},  int'(ifa.frame_start_out), 0);
   endtask

   task automatic chk_idle_b(input string tag);
      chk({tag, " x"},   int'(ifb.pixel_x_out), 0);
      chk({tag, " y"},   int'(ifb.pixel_y_out), 0);
      chk({tag, " vid"}, int'(ifb.video_on_out), 0);
      chk({tag, " hs"},  int'(ifb.h_sync_out), 1);
      chk({tag, " vs"},  int'(ifb.v_sync_out), 1);
      chk({tag, " tk"},  int'(ifb.pixel_tick_out), 0);
      chk({tag, " fs"},  int'(ifb.frame_start_out), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur;
      int ticks, odd_ticks, hs_low, vid_cnt;
      int fs1, fs2, vs_low, maxy, b_ticks, b_vid, b_hs_low;

      // Line-0/1 checkpoints for instance A: position p shows after edge 2p+2
      //              n     x    y  vid hs vs tk fs
      tbl[0]  = '{   1,    0,   0,  0, 1, 1, 0, 0};
      tbl[1]  = '{   2,    0,   0,  1, 1, 1, 1, 1};
      tbl[2]  = '{   3,    0,   0,  1, 1, 1, 0, 0};
      tbl[3]  = '{   4,    1,   0,  1, 1, 1, 1, 0};
      tbl[4]  = '{1280,  639,   0,  1, 1, 1, 1, 0};
      tbl[5]  = '{1282,    0,   0,  0, 1, 1, 1, 0};
      tbl[6]  = '{1312,    0,   0,  0, 1, 1, 1, 0};
      tbl[7]  = '{1314,    0,   0,  0, 0, 1, 1, 0};
      tbl[8]  = '{1504,    0,   0,  0, 0, 1, 1, 0};
      tbl[9]  = '{1506,    0,   0,  0, 1, 1, 1, 0};
      tbl[10] = '{1600,    0,   0,  0, 1, 1, 1, 0};
      tbl[11] = '{1602,    0,   1,  1, 1, 1, 1, 0};
      tbl[12] = '{1612,    5,   1,  1, 1, 1, 1, 0};

      rst_a_n       = 1'b0;
      rst_b_n       = 1'b0;
      ifa.enable_in = 1'b0;
      ifb.enable_in = 1'b0;
      step(2);
      chk_idle_a("rstA");
      chk_idle_b("rstB");

      // ---------------- Instance A: table-driven line walk ----------------
      rst_a_n       = 1'b1;
      ifa.enable_in = 1'b1;
      cur = 0;
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].n - cur);
         cur = tbl[i].n;
         chk($sformatf("A[n=%0d] x", cur),   int'(ifa.pixel_x_out),     tbl[i].x);
         chk($sformatf("A[n=%0d] y", cur),   int'(ifa.pixel_y_out),     tbl[i].y);
         chk($sformatf("A[n=%0d] vid", cur), int'(ifa.video_on_out),    tbl[i].vid);
         chk($sformatf("A[n=%0d] hs", cur),  int'(ifa.h_sync_out),      tbl[i].hs);
         chk($sformatf("A[n=%0d] vs", cur),  int'(ifa.v_sync_out),      tbl[i].vs);
         chk($sformatf("A[n=%0d] tk", cur),  int'(ifa.pixel_tick_out),  tbl[i].tk);
         chk($sformatf("A[n=%0d] fs", cur),  int'(ifa.frame_start_out), tbl[i].fs);
      end

      // ---------------- Instance A: one full line of statistics -----------
      ifa.enable_in = 1'b0;
      step(1);
      ifa.enable_in = 1'b1;
      ticks = 0; odd_ticks = 0; hs_low = 0; vid_cnt = 0;
      for (int n = 1; n <= 1601; n++) begin
         step(1);
         if (ifa.pixel_tick_out) begin
            ticks++;
            if (n % 2 == 1) odd_ticks++;
            if (!ifa.h_sync_out) hs_low++;
            if (ifa.video_on_out) vid_cnt++;
         end
      end
      chk("A line ticks", ticks, 800);
      chk("A ticks on odd edges", odd_ticks, 0);
      chk("A line hsync-low ticks", hs_low, 96);
      chk("A line video ticks", vid_cnt, 640);

      // ---------------- Instance A: disable mid-line, re-enable -----------
      ifa.enable_in = 1'b0;
      step(1);
      ifa.enable_in = 1'b1;
      step(202);
      chk("A pos100 x", int'(ifa.pixel_x_out), 100);
      chk("A pos100 tk", int'(ifa.pixel_tick_out), 1);
      ifa.enable_in = 1'b0;
      step(1);
      chk_idle_a("A disabled");
      step(3);
      chk("A disabled tk stays 0", int'(ifa.pixel_tick_out), 0);
      ifa.enable_in = 1'b1;
      step(1);
      chk("A reenable edge1 fs", int'(ifa.frame_start_out), 0);
      chk("A reenable edge1 tk", int'(ifa.pixel_tick_out), 0);
      step(1);
      chk("A reenable edge2 fs", int'(ifa.frame_start_out), 1);
      chk("A reenable edge2 tk", int'(ifa.pixel_tick_out), 1);
      chk("A reenable edge2 x", int'(ifa.pixel_x_out), 0);
      chk("A reenable edge2 vid", int'(ifa.video_on_out), 1);

      // ---------------- Instance B: full frames with CLOCK_DIV=1 ----------
      rst_b_n       = 1'b1;
      ifb.enable_in = 1'b1;
      fs1 = -1; fs2 = -1; vs_low = 0; maxy = 0; b_ticks = 0; b_vid = 0; b_hs_low = 0;
      for (int n = 1; n <= 400; n++) begin
         step(1);
         if (ifb.frame_start_out) begin
            if (fs1 < 0) fs1 = n;
            else if (fs2 < 0) fs2 = n;
         end
         if (n <= 176) begin
            if (ifb.pixel_tick_out) b_ticks++;
            if (ifb.pixel_tick_out && !ifb.v_sync_out) vs_low++;
            if (ifb.pixel_tick_out && !ifb.h_sync_out) b_hs_low++;
            if (ifb.pixel_tick_out && ifb.video_on_out) b_vid++;
            if (int'(ifb.pixel_y_out) > maxy) maxy = int'(ifb.pixel_y_out);
         end
         if (n == 1) chk("B edge1 tk", int'(ifb.pixel_tick_out), 1);
         if (n == 81) chk("B line5 y", int'(ifb.pixel_y_out), 5);
         if (n == 97) begin
            chk("B line6 y wraps to 0", int'(ifb.pixel_y_out), 0);
            chk("B line6 vid", int'(ifb.video_on_out), 0);
         end
      end
      chk("B first frame_start edge", fs1, 1);
      chk("B frame period", fs2 - fs1, 176);
      chk("B ticks per frame", b_ticks, 176);
      chk("B vsync-low ticks", vs_low, 32);
      chk("B hsync-low ticks", b_hs_low, 33);
      chk("B video ticks", b_vid, 48);
      chk("B max pixel_y", maxy, 5);

      // ---------------- Instance B: disable at (5,3), re-enable -----------
      ifb.enable_in = 1'b0;
      step(1);
      ifb.enable_in = 1'b1;
      step(54);
      chk("B pos(5,3) x", int'(ifb.pixel_x_out), 5);
      chk("B pos(5,3) y", int'(ifb.pixel_y_out), 3);
      chk("B pos(5,3) vid", int'(ifb.video_on_out), 1);
      ifb.enable_in = 1'b0;
      step(1);
      chk_idle_b("B disabled");
      ifb.enable_in = 1'b1;
      step(1);
      chk("B reenable fs", int'(ifb.frame_start_out), 1);
      chk("B reenable tk", int'(ifb.pixel_tick_out), 1);

      // ---------------- Instance B: async reset inside both syncs ---------
      step(139);
      chk("B pos(11,8) hs", int'(ifb.h_sync_out), 0);
      chk("B pos(11,8) vs", int'(ifb.v_sync_out), 0);
      #2;
      rst_b_n = 1'b0;
      #1;
      chk_idle_b("B async reset");
      #1;
      rst_b_n = 1'b1;
      step(1);
      chk("B after reset fs", int'(ifb.frame_start_out), 1);
      chk("B after reset x", int'(ifb.pixel_x_out), 0);
      chk("B after reset y", int'(ifb.pixel_y_out), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
